// File: rtl/ffe_sample_driver.sv
// Buffers upstream samples and feeds them one at a time to a feed-forward equalizer,
// running the setup/load/hold handshake and capturing the result or flagging a timeout.
module ffe_sample_driver #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_STAGES = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  input  logic [DATA_WIDTH-1:0]              s_data,
  output logic                               s_ready,
  output logic                               load_in,
  output logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               data_valid,
  input  logic [DATA_WIDTH-1:0]              data_out,
  output logic                               y_valid,
  output logic [DATA_WIDTH-1:0]              y_data,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               timeout_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int HW = $clog2(NUM_STAGES+2);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [HW-1:0]         hold_cnt_r;
  logic [TW-1:0]         wait_cnt_r;
  logic                  full_s, empty_s, push_s, pop_s;
  logic                  load_nxt_s, capture_s, timeout_s;

  assign full_s  = (fifo_level == LW'(FIFO_DEPTH));
  assign empty_s = (fifo_level == LW'(0));
  assign s_ready = !full_s;
  assign push_s  = s_valid && !full_s;
  assign busy    = (state_r != IDLE);

  // Sample storage; contents are don't-care until the level says otherwise.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_level <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_nxt_s  = 1'b0;
    capture_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        load_nxt_s  = 1'b1;
        state_nxt_s = LOAD;
      end
      LOAD: state_nxt_s = HOLD;
      HOLD: begin
        if (hold_cnt_r == HW'(NUM_STAGES)) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      WAIT: begin
        // A result arriving on the expiry cycle still counts as on time.
        if (data_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = IDLE;
        end else if (wait_cnt_r == TW'(TIMEOUT-1)) begin
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      hold_cnt_r  <= '0;
      wait_cnt_r  <= '0;
      load_in     <= 1'b0;
      data_in     <= '0;
      y_valid     <= 1'b0;
      y_data      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      load_in <= load_nxt_s;
      y_valid <= capture_s;
      if (pop_s)     data_in     <= mem_r[rd_ptr_r];
      if (capture_s) y_data      <= data_out;
      if (timeout_s) timeout_err <= 1'b1;
      if (state_r == LOAD)      hold_cnt_r <= '0;
      else if (state_r == HOLD) hold_cnt_r <= hold_cnt_r + HW'(1);
      if (state_r == HOLD)      wait_cnt_r <= '0;
      else if (state_r == WAIT) wait_cnt_r <= wait_cnt_r + TW'(1);
    end
  end

endmodule

// File: tb/tb_ffe_sample_driver.sv
// Directed bench for ffe_sample_driver: expected results are queued at stimulus time
// and a negedge monitor compares every y_valid strobe against the queue.
module tb_ffe_sample_driver;

  localparam int NS = 2;
  localparam int TO = 15;
  localparam logic [11:0] MASK = 12'h5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = 12'h000;
  logic        s_ready;
  logic        load_in;
  logic [11:0] data_in;
  logic        data_valid = 1'b0;
  logic [11:0] data_out = 12'h000;
  logic        y_valid;
  logic [11:0] y_data;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        timeout_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int load_pulses = 0;
  logic [11:0] exp_q[$];

  ffe_sample_driver #(.DATA_WIDTH(12), .NUM_STAGES(NS), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_in(load_in), .data_in(data_in), .data_valid(data_valid), .data_out(data_out),
    .y_valid(y_valid), .y_data(y_data), .busy(busy), .fifo_level(fifo_level),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every captured result must match the oldest expectation.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (!rst && y_valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_y_valid: got y_data=%0h expected no strobe", y_data);
        end else begin
          e = exp_q.pop_front();
          chk("y_data_scoreboard", y_data, e);
        end
      end
    end
  end

  // Acts as the equalizer for one transaction: result = data_in ^ MASK, one cycle after WAIT entry.
  task automatic serve_one();
    int n = 0;
    while (n < 60 && !load_in) begin
      tick();
      n++;
    end
    if (!load_in) begin
      chk("load_seen", 32'd0, 32'd1);
      return;
    end
    load_pulses++;
    for (int i = 0; i < NS + 2; i++) begin
      tick();
      chk("no_reload_before_wait", load_in, 1'b0);
    end
    data_valid = 1'b1;
    data_out   = data_in ^ MASK;
    tick();
    data_valid = 1'b0;
    chk("no_reload_at_capture", load_in, 1'b0);
  endtask

  task automatic wait_load();
    int n = 0;
    while (n < 60 && !load_in) begin
      tick();
      n++;
    end
    chk("wait_load_seen", load_in, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [11:0] b2b [6];
  int accepted;
  int guard;
  bit saw_full;
  int pulses0;
  int stray_loads;

  initial begin
    b2b[0] = 12'h001; b2b[1] = 12'h7FF; b2b[2] = 12'h800;
    b2b[3] = 12'h155; b2b[4] = 12'hAAA; b2b[5] = 12'h3C3;

    // Reset values
    tick();
    tick();
    chk("rst_load_in", load_in, 1'b0);
    chk("rst_data_in", data_in, 12'h000);
    chk("rst_y_valid", y_valid, 1'b0);
    chk("rst_y_data", y_data, 12'h000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_fifo_level", fifo_level, 3'd0);
    chk("rst_s_ready", s_ready, 1'b1);
    rst = 1'b0;

    // Single sample, with stray results in IDLE and HOLD
    data_valid = 1'b1; data_out = 12'hABC;
    tick();
    data_valid = 1'b0;
    chk("stray_idle_y_data", y_data, 12'h000);
    s_valid = 1'b1; s_data = 12'h400;
    tick();                                  // edge 0
    s_valid = 1'b0;
    chk("single_level_after_push", fifo_level, 3'd1);
    chk("single_busy_e0", busy, 1'b0);
    tick();                                  // edge 1
    chk("single_busy_e1", busy, 1'b1);
    chk("single_data_in_e1", data_in, 12'h400);
    chk("single_load_e1", load_in, 1'b0);
    chk("single_level_e1", fifo_level, 3'd0);
    tick();                                  // edge 2
    chk("single_load_e2", load_in, 1'b1);
    tick();                                  // edge 3
    chk("single_load_e3", load_in, 1'b0);
    chk("single_data_in_e3", data_in, 12'h400);
    data_valid = 1'b1; data_out = 12'hABC;
    tick();                                  // edge 4
    data_valid = 1'b0;
    chk("single_data_in_e4", data_in, 12'h400);
    chk("stray_hold_y_data", y_data, 12'h000);
    tick();                                  // edge 5
    chk("single_data_in_e5", data_in, 12'h400);
    tick();                                  // edge 6: WAIT entry
    chk("single_busy_wait", busy, 1'b1);
    tick();                                  // edge 7
    data_valid = 1'b1; data_out = 12'h123;
    exp_q.push_back(12'h123);
    tick();                                  // edge 8: capture
    data_valid = 1'b0;
    chk("single_y_valid", y_valid, 1'b1);
    chk("single_y_data", y_data, 12'h123);
    chk("single_busy_after", busy, 1'b0);
    tick();
    chk("single_y_valid_one_cycle", y_valid, 1'b0);

    // Back-to-back with s_valid held high
    pulses0  = load_pulses;
    accepted = 0;
    guard    = 0;
    saw_full = 1'b0;
    fork
      begin
        logic rdy;
        s_valid = 1'b1;
        while (accepted < 6 && guard < 200) begin
          s_data = b2b[accepted];
          rdy = s_ready;
          tick();
          guard++;
          if (rdy) begin
            exp_q.push_back(b2b[accepted] ^ MASK);
            accepted++;
          end
          if (fifo_level == 3'd4) begin
            saw_full = 1'b1;
            chk("b2b_s_ready_when_full", s_ready, 1'b0);
          end
        end
        s_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) serve_one();
      end
    join
    chk("b2b_accepted", accepted, 6);
    chk("b2b_saw_full", saw_full, 1'b1);
    chk("b2b_load_pulses", load_pulses - pulses0, 6);
    tick();
    chk("b2b_queue_drained", exp_q.size(), 0);

    // Race: result on the very cycle the timer expires
    do_reset();
    s_valid = 1'b1; s_data = 12'h055;
    tick();
    s_valid = 1'b0;
    wait_load();
    repeat (NS + 2) tick();                  // WAIT entry
    repeat (TO - 1) tick();
    data_valid = 1'b1; data_out = 12'h6E6;
    exp_q.push_back(12'h6E6);
    tick();
    data_valid = 1'b0;
    chk("race_y_valid", y_valid, 1'b1);
    chk("race_timeout_err", timeout_err, 1'b0);
    chk("race_busy", busy, 1'b0);
    tick();
    chk("race_queue_drained", exp_q.size(), 0);

    // Timeout, then a further sample still gets processed
    s_valid = 1'b1; s_data = 12'h0F0;
    tick();
    s_valid = 1'b0;
    wait_load();
    repeat (NS + 2) tick();                  // WAIT entry
    repeat (TO - 1) tick();
    chk("timeout_not_early", timeout_err, 1'b0);
    chk("timeout_busy_before", busy, 1'b1);
    tick();
    chk("timeout_err_set", timeout_err, 1'b1);
    chk("timeout_busy_after", busy, 1'b0);
    s_valid = 1'b1; s_data = 12'h321;
    exp_q.push_back(12'h321 ^ MASK);
    tick();
    s_valid = 1'b0;
    serve_one();
    tick();
    chk("timeout_err_sticky", timeout_err, 1'b1);
    chk("timeout_queue_drained", exp_q.size(), 0);

    // Reset mid-HOLD with three samples queued
    s_valid = 1'b1;
    s_data = 12'h111; tick();
    s_data = 12'h222; tick();
    s_data = 12'h333; tick();
    s_data = 12'h444; tick();
    s_valid = 1'b0;
    chk("midhold_level", fifo_level, 3'd3);
    #2 rst = 1'b1;
    #1;
    chk("midhold_rst_level", fifo_level, 3'd0);
    chk("midhold_rst_s_ready", s_ready, 1'b1);
    chk("midhold_rst_busy", busy, 1'b0);
    chk("midhold_rst_load_in", load_in, 1'b0);
    chk("midhold_rst_data_in", data_in, 12'h000);
    chk("midhold_rst_timeout_err", timeout_err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    stray_loads = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (load_in) stray_loads++;
    end
    chk("midhold_no_load_after_rst", stray_loads, 0);
    chk("midhold_idle_busy", busy, 1'b0);

    // First push right after reset release
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b1; s_data = 12'h2AA;
    exp_q.push_back(12'h2AA ^ MASK);
    tick();
    s_valid = 1'b0;
    chk("first_push_after_rst", fifo_level, 3'd1);
    serve_one();
    tick();
    tick();
    chk("final_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
